// File: rtl/dds_pkg.sv
// Shared DDS definitions: key bit positions, waveform codes, step multipliers
// and the key-controller FSM states.
package dds_pkg;

  localparam int KEY_UP   = 0;
  localparam int KEY_DOWN = 1;
  localparam int KEY_WAVE = 2;
  localparam int KEY_STEP = 3;

  localparam logic [1:0] WAVE_SINE   = 2'd0;
  localparam logic [1:0] WAVE_SQUARE = 2'd1;
  localparam logic [1:0] WAVE_TRI    = 2'd2;
  localparam logic [1:0] WAVE_SAW    = 2'd3;

  localparam int unsigned STEP_MUL [4] = '{1, 10, 100, 1000};

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_APPLY,
    ST_WAIT
  } state_t;

endpackage

// File: rtl/dds_key_ctrl_if.sv
// Key/configuration bundle between the debounce filters, the key controller
// and the DDS core. master = key controller, slave = consumer/driver side.
interface dds_key_ctrl_if #(
  parameter int FW_WIDTH = 32
) ();

  logic [3:0]          key_flag;
  logic                upd_ready;
  logic [FW_WIDTH-1:0] fword;
  logic [1:0]          wave_sel;
  logic [1:0]          step_idx;
  logic                upd_valid;
  logic [7:0]          drop_cnt;

  modport master (
    input  key_flag, upd_ready,
    output fword, wave_sel, step_idx, upd_valid, drop_cnt
  );

  modport slave (
    output key_flag, upd_ready,
    input  fword, wave_sel, step_idx, upd_valid, drop_cnt
  );

endinterface

// File: rtl/dds_key_arb.sv
// Four-input fixed-priority picker: bit 0 wins; reports the one-hot grant,
// the number of requests and how many of them lost.
module dds_key_arb (
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic       any,
  output logic [2:0] nreq,
  output logic [2:0] lose
);

  always_comb begin
    gnt  = req & (~req + 4'd1);
    any  = |req;
    nreq = 3'(req[0]) + 3'(req[1]) + 3'(req[2]) + 3'(req[3]);
    lose = any ? nreq - 3'd1 : 3'd0;
  end

endmodule

// File: rtl/dds_key_ctrl.sv
// Key-driven DDS configuration controller: arbitrates key pulses, updates
// fword/wave_sel/step_idx and offers each change via upd_valid/upd_ready.
// Optional build macro KEY_PEND_EN adds a one-deep pending key event.
module dds_key_ctrl
  import dds_pkg::*;
#(
  parameter int                  FW_WIDTH  = 32,
  parameter logic [FW_WIDTH-1:0] FW_INIT   = 32'd42950,
  parameter logic [FW_WIDTH-1:0] FW_MIN    = 32'd43,
  parameter logic [FW_WIDTH-1:0] FW_MAX    = 32'd2147483648,
  parameter logic [FW_WIDTH-1:0] BASE_STEP = 32'd43
) (
  input logic            clk,
  input logic            rstn,
  dds_key_ctrl_if.master bus
);

  state_t              state, state_n;
  logic [3:0]          evt, evt_n;
  logic [FW_WIDTH-1:0] fword, fword_n, step_val;
  logic [1:0]          wave, wave_n, step, step_n;
  logic [7:0]          drop, drop_n;
  logic [3:0]          gnt;
  logic                any;
  logic [2:0]          nreq, lose, busy_drop;
`ifdef KEY_PEND_EN
  logic                pend_vld, pend_vld_n, st_vld;
  logic [3:0]          pend, pend_n, st_evt;
`endif

  function automatic logic [FW_WIDTH-1:0] fw_up(input logic [FW_WIDTH-1:0] fw,
                                                input logic [FW_WIDTH-1:0] st);
    logic [FW_WIDTH:0] s;
    s = {1'b0, fw} + {1'b0, st};
    return (s > {1'b0, FW_MAX}) ? FW_MAX : s[FW_WIDTH-1:0];
  endfunction

  // A borrow out of the extended difference means the result went below zero.
  function automatic logic [FW_WIDTH-1:0] fw_dn(input logic [FW_WIDTH-1:0] fw,
                                                input logic [FW_WIDTH-1:0] st);
    logic [FW_WIDTH:0] s;
    s = {1'b0, fw} - {1'b0, st};
    return (s[FW_WIDTH] || (s[FW_WIDTH-1:0] < FW_MIN)) ? FW_MIN : s[FW_WIDTH-1:0];
  endfunction

  function automatic logic [7:0] sat_drop(input logic [7:0] c, input logic [2:0] n);
    logic [8:0] s;
    s = {1'b0, c} + {6'd0, n};
    return s[8] ? 8'hFF : s[7:0];
  endfunction

  dds_key_arb u_arb (
    .req  (bus.key_flag),
    .gnt  (gnt),
    .any  (any),
    .nreq (nreq),
    .lose (lose)
  );

  always_comb begin
    unique case (step)
      2'd0:    step_val = FW_WIDTH'(BASE_STEP * STEP_MUL[0]);
      2'd1:    step_val = FW_WIDTH'(BASE_STEP * STEP_MUL[1]);
      2'd2:    step_val = FW_WIDTH'(BASE_STEP * STEP_MUL[2]);
      default: step_val = FW_WIDTH'(BASE_STEP * STEP_MUL[3]);
    endcase
  end

  // Busy-time key handling: an empty pending slot takes the winner, all else drops.
  always_comb begin
`ifdef KEY_PEND_EN
    st_vld    = pend_vld | any;
    st_evt    = pend_vld ? pend : gnt;
    busy_drop = pend_vld ? nreq : lose;
`else
    busy_drop = nreq;
`endif
  end

  always_comb begin
    state_n = state;
    evt_n   = evt;
    fword_n = fword;
    wave_n  = wave;
    step_n  = step;
    drop_n  = drop;
`ifdef KEY_PEND_EN
    pend_vld_n = pend_vld;
    pend_n     = pend;
`endif
    unique case (state)
      ST_IDLE: begin
        if (any) begin
          evt_n   = gnt;
          drop_n  = sat_drop(drop, lose);
          state_n = ST_APPLY;
        end
      end
      ST_APPLY: begin
        drop_n = sat_drop(drop, busy_drop);
`ifdef KEY_PEND_EN
        pend_vld_n = st_vld;
        pend_n     = st_evt;
`endif
        if (evt[KEY_UP])        fword_n = fw_up(fword, step_val);
        else if (evt[KEY_DOWN]) fword_n = fw_dn(fword, step_val);
        else if (evt[KEY_WAVE]) wave_n  = wave + 2'd1;
        else if (evt[KEY_STEP]) step_n  = step + 2'd1;
        state_n = ST_WAIT;
      end
      ST_WAIT: begin
        drop_n = sat_drop(drop, busy_drop);
`ifdef KEY_PEND_EN
        pend_vld_n = st_vld;
        pend_n     = st_evt;
        if (bus.upd_ready) begin
          if (st_vld) begin
            evt_n      = st_evt;
            pend_vld_n = 1'b0;
            state_n    = ST_APPLY;
          end else begin
            state_n = ST_IDLE;
          end
        end
`else
        if (bus.upd_ready) state_n = ST_IDLE;
`endif
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= ST_IDLE;
      evt   <= 4'd0;
      fword <= FW_INIT;
      wave  <= WAVE_SINE;
      step  <= 2'd0;
      drop  <= 8'd0;
`ifdef KEY_PEND_EN
      pend_vld <= 1'b0;
      pend     <= 4'd0;
`endif
    end else begin
      state <= state_n;
      evt   <= evt_n;
      fword <= fword_n;
      wave  <= wave_n;
      step  <= step_n;
      drop  <= drop_n;
`ifdef KEY_PEND_EN
      pend_vld <= pend_vld_n;
      pend     <= pend_n;
`endif
    end
  end

  assign bus.fword     = fword;
  assign bus.wave_sel  = wave;
  assign bus.step_idx  = step;
  assign bus.drop_cnt  = drop;
  assign bus.upd_valid = (state == ST_WAIT);

endmodule

// File: tb/tb_dds_key_ctrl.sv
// Directed bench for dds_key_ctrl; expectations follow KEY_PEND_EN when defined.
module tb_dds_key_ctrl;
  import dds_pkg::*;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  int   checks = 0;
  int   errors = 0;

  dds_key_ctrl_if #(.FW_WIDTH(32)) bus ();

  dds_key_ctrl dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic press(input logic [3:0] keys);
    bus.key_flag = keys;
    tick();
    bus.key_flag = 4'd0;
  endtask

  // Full key transaction with upd_ready high: APPLY, WAIT, back to IDLE.
  task automatic do_key(input logic [3:0] keys);
    press(keys);
    tick();
    check("valid_during_wait", 32'(bus.upd_valid), 32'd1);
    tick();
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    tick();
  endtask

  initial begin
    bus.key_flag  = 4'd0;
    bus.upd_ready = 1'b0;
    tick();
    tick();
    check("rst_fword", bus.fword, 32'd42950);
    check("rst_wave", 32'(bus.wave_sel), 32'(WAVE_SINE));
    check("rst_step", 32'(bus.step_idx), 32'd0);
    check("rst_valid", 32'(bus.upd_valid), 32'd0);
    check("rst_drop", 32'(bus.drop_cnt), 32'd0);
    rstn = 1'b1;
    tick();

    // First freq-up: valid two edges after the pulse, one cycle long.
    bus.upd_ready = 1'b1;
    press(4'b0001);
    check("lat_valid_k", 32'(bus.upd_valid), 32'd0);
    tick();
    check("lat_valid_k1", 32'(bus.upd_valid), 32'd1);
    check("first_up_fword", bus.fword, 32'd42993);
    tick();
    check("valid_one_cycle", 32'(bus.upd_valid), 32'd0);

    // Step size to 1000x, then up and saturating downs.
    do_reset();
    do_key(4'b1000);
    check("step_1", 32'(bus.step_idx), 32'd1);
    do_key(4'b1000);
    check("step_2", 32'(bus.step_idx), 32'd2);
    do_key(4'b1000);
    check("step_3", 32'(bus.step_idx), 32'd3);
    check("step_fword_kept", bus.fword, 32'd42950);
    do_key(4'b0001);
    check("up_1000x", bus.fword, 32'd85950);
    do_key(4'b0010);
    check("down_1", bus.fword, 32'd42950);
    do_key(4'b0010);
    check("down_sat_min", bus.fword, 32'd43);
    do_key(4'b0010);
    check("down_stay_min", bus.fword, 32'd43);

    // Multiple keys in one cycle: lowest bit wins.
    do_key(4'b1101);
    check("prio_fword", bus.fword, 32'd43043);
    check("prio_drop", 32'(bus.drop_cnt), 32'd2);
    check("prio_step_kept", 32'(bus.step_idx), 32'd3);
    do_key(4'b0100);
    check("wave_1", 32'(bus.wave_sel), 32'(WAVE_SQUARE));
    do_key(4'b0100);
    check("wave_2", 32'(bus.wave_sel), 32'(WAVE_TRI));
    do_key(4'b0100);
    check("wave_3", 32'(bus.wave_sel), 32'(WAVE_SAW));
    do_key(4'b0100);
    check("wave_wrap", 32'(bus.wave_sel), 32'(WAVE_SINE));

    // Stalled consumer with two presses arriving while busy.
    bus.upd_ready = 1'b0;
    press(4'b0001);
    tick();
    check("stall_fword", bus.fword, 32'd86043);
    for (int i = 0; i < 20; i++) begin
      bus.key_flag = (i == 4 || i == 9) ? 4'b0001 : 4'b0000;
      tick();
      check("stall_stable", bus.fword, 32'd86043);
    end
    bus.key_flag = 4'd0;
    check("stall_valid_held", 32'(bus.upd_valid), 32'd1);
`ifdef KEY_PEND_EN
    check("stall_drop", 32'(bus.drop_cnt), 32'd3);
`else
    check("stall_drop", 32'(bus.drop_cnt), 32'd4);
`endif
    bus.upd_ready = 1'b1;
    tick();
    check("accept_valid_low", 32'(bus.upd_valid), 32'd0);
    tick();
`ifdef KEY_PEND_EN
    check("pend_applied_valid", 32'(bus.upd_valid), 32'd1);
    check("pend_applied_fword", bus.fword, 32'd129043);
`else
    check("no_pend_valid", 32'(bus.upd_valid), 32'd0);
    check("no_pend_fword", bus.fword, 32'd86043);
`endif
    tick();
    check("stall_done_idle", 32'(bus.upd_valid), 32'd0);

    // Asynchronous reset while waiting, with a key queued behind it.
    bus.upd_ready = 1'b0;
    press(4'b0100);
    tick();
    check("wait_wave", 32'(bus.wave_sel), 32'(WAVE_SQUARE));
    check("wait_valid", 32'(bus.upd_valid), 32'd1);
    press(4'b0001);
    rstn = 1'b0;
    #1;
    check("async_fword", bus.fword, 32'd42950);
    check("async_wave", 32'(bus.wave_sel), 32'd0);
    check("async_step", 32'(bus.step_idx), 32'd0);
    check("async_valid", 32'(bus.upd_valid), 32'd0);
    check("async_drop", 32'(bus.drop_cnt), 32'd0);
    tick();
    rstn = 1'b1;
    bus.upd_ready = 1'b1;
    tick();
    tick();
    tick();
    check("pend_cleared_valid", 32'(bus.upd_valid), 32'd0);
    check("pend_cleared_fword", bus.fword, 32'd42950);

    // drop_cnt saturation: each 4'b1111 press from IDLE drops three keys.
    for (int i = 1; i <= 300; i++) begin
      press(4'b1111);
      tick();
      tick();
      if (i == 84) check("drop_252", 32'(bus.drop_cnt), 32'd252);
      if (i == 85) check("drop_255", 32'(bus.drop_cnt), 32'd255);
    end
    check("drop_sat", 32'(bus.drop_cnt), 32'd255);
    check("sat_run_fword", bus.fword, 32'd55850);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
